seg_scan_drv: RTL and testbench

//  Multiplexed seven-segment scan driver: the decode end of the panel path (index -> one-hot digit strobe, nibble -> segments).

---
 rtl/seg_scan_drv.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_drv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: multiplexed seven-segment scan driver.
// Holds DIGITS hex nibbles and time-multiplexes them onto one active-low
// segment bus (seg[7]=dp, seg[6:0]=g..a) and an active-low one-hot digit strobe.
// New frames arrive over valid/ready and are swapped in only at frame
// boundaries, so a displayed frame never mixes old and new digits.
// Optional feature macro: SEG_LZ_BLANK_EN (leading-zero blanking).
module seg_scan_drv #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic [DIGITS-1:0]     in_mask,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int             CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DIGITS - 1);

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  logic                  bnd;

  logic                  pend_full;
  logic [4*DIGITS-1:0]   pend_data;
  logic [DIGITS-1:0]     pend_dp;
  logic [DIGITS-1:0]     pend_mask;

  logic [4*DIGITS-1:0]   act_data;
  logic [DIGITS-1:0]     act_dp;
  logic [DIGITS-1:0]     act_mask;

  logic                  accept;

  logic [3:0]            nib_p0;
  logic                  dp_p0;
  logic                  mask_p0;
  logic                  lz_p0;
  logic [DIGITS-1:0]     sel_p0;
  logic [7:0]            seg_p0;

  assign bnd      = (idx == IDX_LAST) && (cnt == CNT_LAST);
  assign in_ready = ~pend_full;
  assign accept   = in_valid & in_ready;

  // Dwell prescaler and digit index; index advances when the prescaler wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Single-entry pending buffer: filled by the handshake, drained at the frame boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_mask <= '0;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_data <= in_data;
      pend_dp   <= in_dp;
      pend_mask <= in_mask;
    end else if (bnd && pend_full) begin
      pend_full <= 1'b0;
    end
  end

  // Active frame; starts fully masked so nothing lights before the first load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_data <= '0;
      act_dp   <= '0;
      act_mask <= '1;
    end else if (bnd && pend_full) begin
      act_data <= pend_data;
      act_dp   <= pend_dp;
      act_mask <= pend_mask;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_blank;

  // Leading-zero map: digit i>0 blanks when it and every digit above it is zero or masked.
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run & (act_mask[i] | (act_data[4*i +: 4] == 4'h0));
      if (i > 0) lz_blank[i] = run;
    end
  end
`endif

  // Stage p0: select the current digit's fields and build its segment pattern.
  always_comb begin
    nib_p0  = 4'h0;
    dp_p0   = 1'b0;
    mask_p0 = 1'b1;
    lz_p0   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        nib_p0  = act_data[4*i +: 4];
        dp_p0   = act_dp[i];
        mask_p0 = act_mask[i];
`ifdef SEG_LZ_BLANK_EN
        lz_p0   = lz_blank[i];
`endif
      end
    end
    sel_p0 = ~(DIGITS'(1) << idx);
    seg_p0 = (mask_p0 | lz_p0) ? 8'hFF : {~dp_p0, hex7(nib_p0)};
  end

  // Stage p1: registered outputs; first cycle of every dwell is dark to stop ghosting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_sel    <= '1;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= bnd;
      if (cnt == '0) begin
        dig_sel <= '1;
        seg     <= 8'hFF;
      end else begin
        dig_sel <= sel_p0;
        seg     <= seg_p0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv (DIGITS=8, SCAN_DIV=4).
// Expected frames (8 segment bytes, digit k in byte k) are queued when a frame
// is accepted; the monitor pops one at each frame_done and checks every cycle
// of the following scan against it.
module tb_seg_scan_drv;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam logic [63:0] BLANK = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_dp;
  logic [7:0]  in_mask;
  logic [7:0]  dig_sel;
  logic [7:0]  seg;
  logic        frame_done;

  int tests;
  int fails;
  logic [63:0] q[$];

  seg_scan_drv #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dp      (in_dp),
    .in_mask    (in_mask),
    .dig_sel    (dig_sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Offer a frame and hold it until accepted; queue its expected display.
  task automatic send(input logic [31:0] d, input logic [7:0] p, input logic [7:0] m,
                      input logic [63:0] e, output int waited);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_dp    = p;
    in_mask  = m;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("accept_timeout");
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ready_low", 32'(in_ready), 32'd0);
    waited = n;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    if (!frame_done) fail_now("frame_done_timeout");
  endtask

  // Monitor: follows the scan position from frame_done and checks every output cycle.
  initial begin
    logic [63:0] cur;
    logic [7:0]  esel;
    int pos;
    int k;
    int r;
    bit synced;
    cur = BLANK;
    pos = 0;
    synced = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur = BLANK;
        synced = 1'b0;
        pos = 0;
        q.delete();
      end else begin
        chk("onehot", 32'($countones(~dig_sel) <= 1), 32'd1);
        if (frame_done) begin
          chk("fd_sel", 32'(dig_sel), 32'h7F);
          chk("fd_seg", 32'(seg), 32'(cur[63:56]));
          if (synced) chk("period", 32'(pos), 32'd32);
          if (q.size() > 0) cur = q.pop_front();
          synced = 1'b1;
          pos = 1;
        end else if (synced) begin
          if (pos >= 32) begin
            fail_now("fd_missing");
            synced = 1'b0;
          end else begin
            k = (pos - 1) / 4;
            r = (pos - 1) % 4;
            if (r == 0) begin
              chk("dead_sel", 32'(dig_sel), 32'hFF);
              chk("dead_seg", 32'(seg), 32'hFF);
            end else begin
              esel = ~(8'h01 << k);
              chk("lit_sel", 32'(dig_sel), 32'(esel));
              chk("lit_seg", 32'(seg), 32'(cur[8*k +: 8]));
            end
            pos++;
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [63:0] f6;
    logic [63:0] fb;
    int w;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_dp = '0;
    in_mask = '0;

`ifdef SEG_LZ_BLANK_EN
    f6 = 64'hFFFF_FFFF_FF8E_C0C0;
    fb = 64'hFFFF_FFFF_FFFF_FF79;
`else
    f6 = 64'hC0C0_C0C0_C08E_C0C0;
    fb = 64'h4040_4040_4040_4079;
`endif

    // Reset held
    repeat (3) @(negedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_sel", 32'(dig_sel), 32'hFF);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Counting digits 0..7
    send(32'h7654_3210, 8'h00, 8'h00, 64'hF882_9299_B0A4_F9C0, w);
    wait_fd();
    chk("ready_after_bnd", 32'(in_ready), 32'd1);
    wait_fd();

    // dp on digit 0, digit 7 masked (its nibble and dp must not show)
    repeat (3) @(negedge clk);
    send(32'hF654_3218, 8'h81, 8'h80, 64'hFF82_9299_B0A4_F900, w);
    wait_fd();
    wait_fd();

    // Single non-zero digit among zeros
    repeat (3) @(negedge clk);
    send(32'h0000_0F00, 8'h00, 8'h00, f6, w);
    wait_fd();
    wait_fd();

    // Back-to-back: B must wait for A to drain, then show a frame later
    repeat (3) @(negedge clk);
    send(32'h89AB_CDEF, 8'h00, 8'h00, 64'h8090_8883_C6A1_868E, w);
    send(32'h0000_0001, 8'hFF, 8'h00, fb, w);
    chk("b_held", 32'(w > 0), 32'd1);
    wait_fd();
    wait_fd();

    // Mid-frame reset with a pending frame: outputs go dark at once, pending is dropped
    repeat (5) @(negedge clk);
    send(32'h7654_3210, 8'h00, 8'h00, 64'hF882_9299_B0A4_F9C0, w);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_sel", 32'(dig_sel), 32'hFF);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_fd", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    wait_fd();
    wait_fd();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
